// File: rtl/bridge_to_mem_serializer.sv
// Queues 32-bit bridge writes and serialises each into 32/MEM_WIDTH memory beats
// with incrementing byte addresses and a ready/valid handshake toward memory.
module bridge_to_mem_serializer #(
    parameter int MEM_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BIG_ENDIAN = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          bridge_addr,
    input  logic [31:0]          bridge_wr_data,
    input  logic                 bridge_wr,
    output logic [31:0]          mem_address,
    output logic [MEM_WIDTH-1:0] mem_data,
    output logic                 mem_wr,
    input  logic                 mem_ready,
    output logic                 busy,
    output logic                 overflow
);
    localparam int BEATS = 32 / MEM_WIDTH;
    localparam int STEP  = MEM_WIDTH / 8;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(BEATS + 1);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    typedef enum logic {IDLE, ACTIVE} state_t;

    entry_t         fifo_q [FIFO_DEPTH];
    entry_t         head;
    logic [AW:0]    wr_ptr, rd_ptr;
    logic           empty, full, push, pop, accept, last;
    state_t         state, state_nxt;
    logic [31:0]    shreg, shift_nxt;
    logic [CW-1:0]  cnt;
    logic [MEM_WIDTH-1:0] chunk;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = bridge_wr && !full;
    assign head  = fifo_q[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr[AW-1:0]] <= '{addr: bridge_addr, data: bridge_wr_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (bridge_wr && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    assign last = (cnt == CW'(1));

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        accept    = 1'b0;
        mem_wr    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                mem_wr = 1'b1;
                if (mem_ready) begin
                    accept = 1'b1;
                    // Chain straight into the next word so there is no idle beat.
                    if (last) begin
                        if (!empty) pop = 1'b1;
                        else        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    generate
        if (BEATS == 1) begin : g_single
            assign shift_nxt = shreg;
        end else if (BIG_ENDIAN != 0) begin : g_msb_first
            assign shift_nxt = {shreg[31-MEM_WIDTH:0], {MEM_WIDTH{1'b0}}};
        end else begin : g_lsb_first
            assign shift_nxt = {{MEM_WIDTH{1'b0}}, shreg[31:MEM_WIDTH]};
        end
        if (BIG_ENDIAN != 0) begin : g_msb_chunk
            assign chunk = shreg[31 -: MEM_WIDTH];
        end else begin : g_lsb_chunk
            assign chunk = shreg[MEM_WIDTH-1:0];
        end
    endgenerate

    // Address stays on the final beat of a word so it holds its last value when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg       <= '0;
            cnt         <= '0;
            mem_address <= '0;
        end else if (pop) begin
            shreg       <= head.data;
            cnt         <= CW'(BEATS);
            mem_address <= head.addr;
        end else if (accept) begin
            shreg <= shift_nxt;
            cnt   <= cnt - CW'(1);
            if (!last) mem_address <= mem_address + 32'(STEP);
        end
    end

    assign mem_data = mem_wr ? chunk : '0;
    assign busy     = !empty || (state == ACTIVE);

endmodule

// File: tb/tb_bridge_to_mem_serializer.sv
// Drives an 8-bit little-endian and a 16-bit big-endian instance from shared
// bridge inputs and scores every accepted beat against per-word expectations.
module tb_bridge_to_mem_serializer;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] bridge_addr = '0, bridge_wr_data = '0;
    logic        bridge_wr = 1'b0, mem_ready = 1'b1;
    logic [31:0] ma8, ma16;
    logic [7:0]  md8;
    logic [15:0] md16;
    logic        mw8, mw16, busy8, busy16, ov8, ov16;

    int checks = 0, errors = 0;
    int beats8 = 0, beats16 = 0, pushed = 0;
    logic [63:0] exp8[$], exp16[$];

    bridge_to_mem_serializer #(.MEM_WIDTH(8), .FIFO_DEPTH(FD), .BIG_ENDIAN(0)) u8 (
        .clk(clk), .reset_n(reset_n), .bridge_addr(bridge_addr), .bridge_wr_data(bridge_wr_data),
        .bridge_wr(bridge_wr), .mem_address(ma8), .mem_data(md8), .mem_wr(mw8),
        .mem_ready(mem_ready), .busy(busy8), .overflow(ov8));

    bridge_to_mem_serializer #(.MEM_WIDTH(16), .FIFO_DEPTH(FD), .BIG_ENDIAN(1)) u16 (
        .clk(clk), .reset_n(reset_n), .bridge_addr(bridge_addr), .bridge_wr_data(bridge_wr_data),
        .bridge_wr(bridge_wr), .mem_address(ma16), .mem_data(md16), .mem_wr(mw16),
        .mem_ready(mem_ready), .busy(busy16), .overflow(ov16));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected beats of one accepted word, straight from the beat-order rules.
    task automatic model_word(input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < 4; k++)
            exp8.push_back({a + 32'(k), 24'b0, 8'(d >> (8 * k))});
        for (int k = 0; k < 2; k++)
            exp16.push_back({a + 32'(2 * k), 16'b0, 16'(d >> (16 * (1 - k)))});
    endtask

    task automatic drive_word(input logic [31:0] a, input logic [31:0] d, input bit acc);
        bridge_addr = a;
        bridge_wr_data = d;
        bridge_wr = 1'b1;
        if (acc) model_word(a, d);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        bridge_wr = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        mem_ready = 1'b1;
        while ((busy8 || busy16) && n < 2000) begin
            step();
            n++;
        end
        step();
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL drain: busy8=%0b busy16=%0b still high, required 0", busy8, busy16);
        end
    endtask

    task automatic monitor;
        logic [63:0] e;
        logic h8 = 1'b0, h16 = 1'b0;
        logic [31:0] ha8 = '0, ha16 = '0;
        logic [7:0] hd8 = '0;
        logic [15:0] hd16 = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                h8 = 1'b0;
                h16 = 1'b0;
            end else begin
                if (h8) begin
                    checks++;
                    if (mw8 !== 1'b1 || ma8 !== ha8 || md8 !== hd8) begin
                        errors++;
                        $display("FAIL hold8: got wr=%b %h/%h required 1 %h/%h", mw8, ma8, md8, ha8, hd8);
                    end
                end
                if (h16) begin
                    checks++;
                    if (mw16 !== 1'b1 || ma16 !== ha16 || md16 !== hd16) begin
                        errors++;
                        $display("FAIL hold16: got wr=%b %h/%h required 1 %h/%h", mw16, ma16, md16, ha16, hd16);
                    end
                end
                if (!mw8) begin
                    checks++;
                    if (md8 !== 8'h0) begin
                        errors++;
                        $display("FAIL idle_data8: got %h required 0", md8);
                    end
                end
                if (!mw16) begin
                    checks++;
                    if (md16 !== 16'h0) begin
                        errors++;
                        $display("FAIL idle_data16: got %h required 0", md16);
                    end
                end
                if (mw8 && mem_ready) begin
                    beats8++;
                    checks++;
                    if (exp8.size() == 0) begin
                        errors++;
                        $display("FAIL beat8: unexpected beat %h/%h, none required", ma8, md8);
                    end else begin
                        e = exp8.pop_front();
                        if ({ma8, 24'b0, md8} !== e) begin
                            errors++;
                            $display("FAIL beat8: got %h/%h required %h/%h", ma8, md8, e[63:32], e[7:0]);
                        end
                    end
                end
                if (mw16 && mem_ready) begin
                    beats16++;
                    checks++;
                    if (exp16.size() == 0) begin
                        errors++;
                        $display("FAIL beat16: unexpected beat %h/%h, none required", ma16, md16);
                    end else begin
                        e = exp16.pop_front();
                        if ({ma16, 16'b0, md16} !== e) begin
                            errors++;
                            $display("FAIL beat16: got %h/%h required %h/%h", ma16, md16, e[63:32], e[15:0]);
                        end
                    end
                end
                h8 = mw8 && !mem_ready;   ha8 = ma8;   hd8 = md8;
                h16 = mw16 && !mem_ready; ha16 = ma16; hd16 = md16;
            end
        end
    endtask

    task automatic check_empty_queues(input string name);
        checks++;
        if (exp8.size() != 0 || exp16.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: %0d/%0d beats outstanding, required 0/0", name, exp8.size(), exp16.size());
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mw8, busy8, ov8, ma8, md8} !== '0) begin
            errors++;
            $display("FAIL reset8: got wr=%b busy=%b ov=%b a=%h d=%h required all 0", mw8, busy8, ov8, ma8, md8);
        end
        checks++;
        if ({mw16, busy16, ov16, ma16, md16} !== '0) begin
            errors++;
            $display("FAIL reset16: got wr=%b busy=%b ov=%b a=%h d=%h required all 0", mw16, busy16, ov16, ma16, md16);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single;
        logic [7:0]  ed8 [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        logic [15:0] ed16[2] = '{16'hAABB, 16'hCCDD};
        mem_ready = 1'b1;
        drive_word(32'h100, 32'hAABBCCDD, 1'b1);
        step();
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b1 || mw8 !== 1'b0) begin
            errors++;
            $display("FAIL latency_c1: got busy=%b wr=%b required busy=1 wr=0", busy8, mw8);
        end
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if (c <= 5 && (mw8 !== 1'b1 || ma8 !== 32'h100 + 32'(c - 2) || md8 !== ed8[c-2])) begin
                errors++;
                $display("FAIL single8_c%0d: got %b %h/%h required 1 %h/%h", c, mw8, ma8, md8, 32'h100 + 32'(c - 2), ed8[c-2]);
            end else if (c == 6 && (mw8 !== 1'b0 || busy8 !== 1'b0)) begin
                errors++;
                $display("FAIL busy_fall8: got wr=%b busy=%b required 0 0", mw8, busy8);
            end
            if (c <= 3) begin
                checks++;
                if (mw16 !== 1'b1 || ma16 !== 32'h100 + 32'(2 * (c - 2)) || md16 !== ed16[c-2]) begin
                    errors++;
                    $display("FAIL single16_c%0d: got %b %h/%h required 1 %h/%h", c, mw16, ma16, md16, 32'h100 + 32'(2 * (c - 2)), ed16[c-2]);
                end
            end else if (c == 4) begin
                checks++;
                if (busy16 !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_fall16: got %b required 0", busy16);
                end
            end
        end
        step();
        check_empty_queues("single");
    endtask

    task automatic test_backpressure;
        mem_ready = 1'b1;
        drive_word(32'h100, 32'hAABBCCDD, 1'b1);
        step();
        step();
        step();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (mw8 !== 1'b1 || ma8 !== 32'h101 || md8 !== 8'hCC) begin
                errors++;
                $display("FAIL stall_c%0d: got %b %h/%h required 1 00000101/cc", i, mw8, ma8, md8);
            end
            step();
        end
        drain();
        check_empty_queues("backpressure");
    endtask

    task automatic test_back_to_back;
        mem_ready = 1'b1;
        for (int c = 0; c <= 18; c++) begin
            if (c < 4) drive_word($urandom, $urandom, 1'b1);
            @(negedge clk);
            if (c >= 2) begin
                checks++;
                if (mw8 !== (c <= 17)) begin
                    errors++;
                    $display("FAIL stream8_c%0d: got wr=%b required %b", c, mw8, c <= 17);
                end
            end
            if (c >= 2 && c <= 10) begin
                checks++;
                if (mw16 !== (c <= 9)) begin
                    errors++;
                    $display("FAIL stream16_c%0d: got wr=%b required %b", c, mw16, c <= 9);
                end
            end
            step();
        end
        checks++;
        if (ov8 !== 1'b0 || ov16 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overflow: got %b/%b required 0/0", ov8, ov16);
        end
        check_empty_queues("back_to_back");
    endtask

    task automatic test_overflow;
        mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_word($urandom, $urandom, i < 5);
            if (i == 5) begin
                @(negedge clk);
                checks++;
                if (ov8 !== 1'b0 || ov16 !== 1'b0) begin
                    errors++;
                    $display("FAIL overflow_early: got %b/%b required 0/0", ov8, ov16);
                end
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (ov8 !== 1'b1 || ov16 !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: got %b/%b required 1/1", ov8, ov16);
        end
        step();
        drain();
        check_empty_queues("overflow");
        checks++;
        if (ov8 !== 1'b1 || ov16 !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got %b/%b required 1/1", ov8, ov16);
        end
    endtask

    task automatic test_wrap_reset;
        mem_ready = 1'b1;
        drive_word(32'hFFFFFFFE, $urandom, 1'b1);
        step();
        drain();
        check_empty_queues("wrap");
        drive_word(32'hFFFFFFFE, $urandom, 1'b1);
        repeat (4) step();
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (mw8 !== 1'b0 || busy8 !== 1'b0 || busy16 !== 1'b0 || ov8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got wr=%b busy=%b/%b ov=%b required all 0", mw8, busy8, busy16, ov8);
        end
        checks++;
        if (exp8.size() != 2 || exp16.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_beats: %0d/%0d beats left, required 2/0", exp8.size(), exp16.size());
        end
        exp8.delete();
        exp16.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (10) step();
        checks++;
        if (busy8 !== 1'b0 || busy16 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b/%b required 0/0", busy8, busy16);
        end
    endtask

    task automatic test_random;
        beats8 = 0;
        beats16 = 0;
        pushed = 0;
        for (int n = 0; n < 600; n++) begin
            mem_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && pushed - beats8 / 4 < FD && pushed - beats16 / 2 < FD) begin
                drive_word($urandom, $urandom, 1'b1);
                pushed++;
            end
            step();
        end
        drain();
        check_empty_queues("random");
        checks++;
        if (ov8 !== 1'b0 || ov16 !== 1'b0 || pushed == 0) begin
            errors++;
            $display("FAIL random_overflow: got %b/%b pushed=%0d required 0/0 and pushes", ov8, ov16, pushed);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_wrap_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bridge_to_mem_serializer.md
# bridge_to_mem_serializer

Parametrised successor to the 32-bit bridge-to-byte write path. It queues 32-bit APF bridge writes in a small FIFO and serialises each word into 32/MEM_WIDTH narrower memory beats with incrementing addresses, selectable beat order and a ready/valid backpressure handshake on the memory side. It sits between the bridge write decode and a loader-side memory port (BRAM, SDRAM controller front end), replacing the fixed 8-bit, no-backpressure version.

## Interface
Parameters:
- MEM_WIDTH, 8: memory beat width in bits; legal values 8, 16, 32. BEATS = 32/MEM_WIDTH.
- FIFO_DEPTH, 4: number of queued bridge words; power of two, at least 2.
- BIG_ENDIAN, 0: 0 = least-significant chunk first; 1 = most-significant chunk first.

Ports:
- clk  in  1  single clock for the whole block.
- reset_n  in  1  asynchronous, active-low reset.
- bridge_addr  in  32  byte address of the first beat of the word.
- bridge_wr_data  in  32  word to write.
- bridge_wr  in  1  one-cycle push strobe; sampled on the rising edge of clk.
- mem_address  out  32  byte address of the current beat.
- mem_data  out  MEM_WIDTH  beat data.
- mem_wr  out  1  beat valid.
- mem_ready  in  1  memory accepts the beat in a cycle where mem_wr && mem_ready.
- busy  out  1  high while the FIFO is non-empty or a word is being serialised.
- overflow  out  1  sticky; set when a push is dropped; cleared only by reset.

## Operation
- FIFO stores {bridge_addr, bridge_wr_data} per entry.
- Push: bridge_wr && !full writes one entry. bridge_wr && full drops the entry and sets overflow. Full is evaluated before any pop in the same cycle, so a pop does not make room for a simultaneous push.
- Serialiser states:
  - IDLE: mem_wr = 0. If the FIFO is non-empty, pop the head into the shift register, load the beat counter with BEATS and the address register with the entry's address, then go to ACTIVE.
  - ACTIVE: mem_wr = 1. On each accepted beat (mem_ready = 1):
    - the address advances by MEM_WIDTH/8;
    - the shift register advances one chunk;
    - the counter decrements.
  - On acceptance of the last beat:
    - FIFO non-empty: pop the next entry in the same cycle and stay in ACTIVE, with no bubble.
    - FIFO empty: go to IDLE.
- Beat order:
  - BIG_ENDIAN = 0: beat k carries data[k*MEM_WIDTH +: MEM_WIDTH].
  - BIG_ENDIAN = 1: beat k carries data[31-k*MEM_WIDTH -: MEM_WIDTH].
- Beat k address is bridge_addr + k*(MEM_WIDTH/8), computed modulo 2^32 (wraps past 32'hFFFFFFFF). No alignment is forced.
- mem_address, mem_data and mem_wr hold stable while mem_wr && !mem_ready.
- mem_data = 0 and mem_address holds its last value while mem_wr = 0.
- MEM_WIDTH = 32: one beat per word, and the block acts as a buffered, backpressured pass-through.

## Timing
- Reset (asynchronous assert, synchronous-safe release) sets:
  - mem_wr = 0, mem_data = 0, mem_address = 0, busy = 0, overflow = 0;
  - FIFO empty, state IDLE.
- Reset asserted mid-word abandons the in-flight beats and discards all queued entries.
- Latency: bridge_wr in cycle 0, with an empty FIFO and IDLE state, gives mem_wr high from cycle 2. busy is high from cycle 1.
- Throughput with mem_ready tied high: one beat per cycle sustained, so one word per BEATS cycles.
- busy falls in the cycle after the last beat of the last queued word is accepted.
- overflow rises in the cycle after the dropping push.

## Test plan
- Single word, MEM_WIDTH=8, BIG_ENDIAN=0, mem_ready=1: addr 32'h100, data 32'hAABBCCDD -> beats (100,DD),(101,CC),(102,BB),(103,AA) in cycles 2–5; busy falls at cycle 6.
- Same word, BIG_ENDIAN=1, MEM_WIDTH=16 -> beats (100,AABB),(102,CCDD).
- Backpressure: MEM_WIDTH=8, mem_ready low for 3 cycles at beat 1 -> (101,CC) held stable 4 cycles; no beat lost or repeated.
- Back-to-back: pushes every cycle for 4 words, MEM_WIDTH=8, FIFO_DEPTH=4 -> 16 consecutive mem_wr cycles with no gap; overflow stays 0.
- Overflow: mem_ready=0 and 6 pushes with FIFO_DEPTH=4 -> first word in the serialiser, next 4 queued, 6th dropped; overflow=1 from the next cycle; only 5 words are emitted after mem_ready rises.
- Wrap and reset: addr 32'hFFFFFFFE, MEM_WIDTH=8 -> addresses FFFFFFFE, FFFFFFFF, 0, 1. Asserting reset_n=0 after beat 1 forces mem_wr=0 and busy=0 immediately, and no further beats appear after release.
